// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- instruction fetch stage of the RISC-V core.
//
// Holds the program counter, drives the word address to a synchronous-read
// code ROM (1-cycle latency, no enable), pairs each returned word with its
// PC and buffers it in a 2-entry queue that feeds decode over valid/ready.
// Execute can redirect fetch at any time; a redirect flushes everything
// younger than the new PC.
//
// Ports:
//   m_clock        in   1  clock, rising edge
//   p_reset        in   1  asynchronous reset, active low
//   rom_addr       out 32  ROM word address {2'b00, fetch_pc[31:2]}
//   rom_rdata      in  32  ROM data for rom_addr of the previous cycle
//   out_valid      out  1  instruction available to decode
//   out_ready      in   1  decode accepts this cycle
//   out_inst       out 32  instruction word at queue head
//   out_pc         out 32  byte PC of out_inst
//   redirect_valid in   1  flush and restart fetch
//   redirect_pc    in  32  new byte PC (bits [1:0] forced to 0)
// ---------------------------------------------------------------------------
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        m_clock,
   input  logic        p_reset,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   // Queue capacity as used by the issue credit check.
   localparam logic [2:0] QCAP = 3'(QDEPTH);

   // ----------------------------------------------------------------------
   // State
   // ----------------------------------------------------------------------
   logic [31:0] fetch_pc_q,    fetch_pc_d;
   logic        inflight_q,    inflight_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic        head_q,        head_d;
   logic [1:0]  count_q,       count_d;
   logic [31:0] ent_inst_q [2];
   logic [31:0] ent_pc_q   [2];

   // ----------------------------------------------------------------------
   // Handshake / credit
   // ----------------------------------------------------------------------
   logic       pop;
   logic       push;
   logic       issue;
   logic       tail;
   logic [2:0] occ_after;

   // Low PC bits of a redirect target are discarded by design.
   logic unused_redirect_lo;
   assign unused_redirect_lo = ^redirect_pc[1:0];

   // The head word is killed in a redirect cycle, so it cannot transfer.
   assign out_valid = (count_q != 2'd0) && !redirect_valid;
   assign pop       = out_valid && out_ready;

   // Returned data only counts while no redirect is flushing it.
   assign push      = inflight_q && !redirect_valid;

   // Slots committed next cycle: queued + in flight - leaving now. Issuing
   // only while this stays below capacity means every word in flight has a
   // guaranteed slot, so the queue can never overflow.
   assign occ_after = 3'(count_q) + 3'(inflight_q) - 3'(pop);
   assign issue     = !redirect_valid && (occ_after < QCAP);

   // Write slot. With count==2 a push only happens alongside a pop, in which
   // case head+2 == head is exactly the slot being vacated.
   assign tail      = head_q ^ count_q[0];

   // fetch_pc only moves on issue or redirect, so the ROM address is frozen
   // on non-issue cycles and the data returned for it is simply ignored.
   assign rom_addr  = {2'b00, fetch_pc_q[31:2]};
   assign out_inst  = ent_inst_q[head_q];
   assign out_pc    = ent_pc_q[head_q];

   // ----------------------------------------------------------------------
   // Next state
   // ----------------------------------------------------------------------
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      head_d        = head_q;
      count_d       = count_q;

      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         head_d     = 1'b0;
         count_d    = 2'd0;
      end else begin
         if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;   // wraps silently at 2^32
         end
         if (pop) begin
            head_d = ~head_q;
         end
         count_d = count_q + 2'(push) - 2'(pop);
      end
   end

   // ----------------------------------------------------------------------
   // Registers
   // ----------------------------------------------------------------------
   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'd0;
         head_q        <= 1'b0;
         count_q       <= 2'd0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         head_q        <= head_d;
         count_q       <= count_d;
      end
   end

   // Queue storage. Entries reset to zero so out_inst/out_pc read 0 after
   // reset; afterwards stale entries are harmless because out_valid gates them.
   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         for (int i = 0; i < 2; i++) begin
            ent_inst_q[i] <= 32'd0;
            ent_pc_q[i]   <= 32'd0;
         end
      end else if (push) begin
         ent_inst_q[tail] <= rom_rdata;
         ent_pc_q[tail]   <= inflight_pc_q;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

   logic        m_clock = 1'b0;
   logic        p_reset;
   logic [31:0] rom_addr;
   logic [31:0] rom_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int nvec = 0;
   int nerr = 0;

   inst_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
      .m_clock        (m_clock),
      .p_reset        (p_reset),
      .rom_addr       (rom_addr),
      .rom_rdata      (rom_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 m_clock = ~m_clock;

   // ROM model: synchronous read, word index tagged into the data.
   always @(posedge m_clock) rom_rdata <= 32'hA000_0000 + rom_addr;

   task automatic tick;
      @(posedge m_clock);
      #1;
   endtask

   // Expect a valid head word at (pc, inst).
   task automatic expect_word(input string name, input logic [31:0] pc, input logic [31:0] inst);
      nvec++;
      if (out_valid !== 1'b1 || out_pc !== pc || out_inst !== inst) begin
         nerr++;
         $display("FAIL %s: got v=%b pc=%h inst=%h, want v=1 pc=%h inst=%h",
                  name, out_valid, out_pc, out_inst, pc, inst);
      end
   endtask

   task automatic expect_idle(input string name);
      nvec++;
      if (out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL %s: out_valid=%b, want 0", name, out_valid);
      end
   endtask

   task automatic expect_addr(input string name, input logic [31:0] a);
      nvec++;
      if (rom_addr !== a) begin
         nerr++;
         $display("FAIL %s: rom_addr=%h, want %h", name, rom_addr, a);
      end
   endtask

   task automatic test_reset;
      p_reset = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
      tick; tick;
      expect_idle("reset_valid");
      nvec++;
      if (out_pc !== 32'd0 || out_inst !== 32'd0) begin
         nerr++;
         $display("FAIL reset_out: pc=%h inst=%h, want 0/0", out_pc, out_inst);
      end
      expect_addr("reset_addr", 32'd0);
      p_reset = 1'b1;
      tick;                               // edge 1 after release
      expect_idle("first_edge");
      tick;                               // edge 2
      expect_word("first_word", 32'h0, 32'hA000_0000);
   endtask

   task automatic test_stream_stall;
      tick; expect_word("stream1", 32'h4, 32'hA000_0001);
      tick; expect_word("stream2", 32'h8, 32'hA000_0002);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         expect_word("stall_hold", 32'h8, 32'hA000_0002);
         expect_addr("stall_addr", 32'h4);
      end
      out_ready = 1'b1;
      #1 expect_word("release0", 32'h8, 32'hA000_0002);
      tick; expect_word("release1", 32'hC, 32'hA000_0003);
      tick; expect_word("release2", 32'h10, 32'hA000_0004);
   endtask

   task automatic test_redirect;
      out_ready = 1'b0;
      tick; tick;                         // fill: 0x10 and 0x14 queued
      expect_word("fill_head", 32'h10, 32'hA000_0004);
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      #1 expect_idle("redir_cycle");
      tick;
      redirect_valid = 1'b0; out_ready = 1'b1;
      #1 expect_idle("redir_next");
      expect_addr("redir_addr", 32'h40);
      tick; expect_idle("redir_issue");
      tick; expect_word("redir_word", 32'h100, 32'hA000_0040);
      tick; expect_word("redir_word2", 32'h104, 32'hA000_0041);
   endtask

   task automatic test_back_to_back;
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      #1 expect_idle("b2b_first");
      tick;
      redirect_pc = 32'h80;
      #1 expect_idle("b2b_second");
      tick;
      redirect_valid = 1'b0;
      tick; expect_idle("b2b_issue");
      tick; expect_word("b2b_word", 32'h80, 32'hA000_0020);
      tick; expect_word("b2b_word2", 32'h84, 32'hA000_0021);
   endtask

   task automatic test_wrap;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick;
      redirect_valid = 1'b0;
      #1 expect_addr("wrap_addr", 32'h3FFF_FFFF);
      tick; tick;
      expect_word("wrap_top", 32'hFFFF_FFFC, 32'hDFFF_FFFF);
      tick; expect_word("wrap_zero", 32'h0, 32'hA000_0000);
      tick; expect_word("wrap_four", 32'h4, 32'hA000_0001);
   endtask

   task automatic test_random_ready;
      logic [31:0] exp_pc;
      int          xfers;
      exp_pc = 32'h8;                     // head after test_wrap shows 0x4, popped next edge
      tick;
      xfers = 0;
      for (int i = 0; i < 1000; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (out_valid) begin
            nvec++;
            if (out_pc !== exp_pc || out_inst !== 32'hA000_0000 + (exp_pc >> 2)) begin
               nerr++;
               $display("FAIL rand_seq: pc=%h inst=%h, want pc=%h inst=%h",
                        out_pc, out_inst, exp_pc, 32'hA000_0000 + (exp_pc >> 2));
            end
            if (out_ready) begin
               exp_pc = exp_pc + 32'd4;
               xfers++;
            end
         end
         tick;
      end
      nvec++;
      if (xfers < 300) begin
         nerr++;
         $display("FAIL rand_rate: %0d transfers, want at least 300", xfers);
      end
   endtask

   task automatic test_mid_reset;
      out_ready = 1'b0;
      tick; tick; tick;
      nvec++;
      if (out_valid !== 1'b1) begin
         nerr++;
         $display("FAIL mid_fill: out_valid=%b, want 1", out_valid);
      end
      #2 p_reset = 1'b0;
      #1 expect_idle("mid_async");
      nvec++;
      if (out_pc !== 32'd0 || out_inst !== 32'd0) begin
         nerr++;
         $display("FAIL mid_out: pc=%h inst=%h, want 0/0", out_pc, out_inst);
      end
      expect_addr("mid_addr", 32'd0);
      tick;
      expect_idle("mid_held");
      p_reset = 1'b1; out_ready = 1'b1;
      tick; expect_idle("mid_edge1");
      tick; expect_word("mid_restart", 32'h0, 32'hA000_0000);
      tick; expect_word("mid_restart2", 32'h4, 32'hA000_0001);
   endtask

   initial begin
      test_reset;
      test_stream_stall;
      test_redirect;
      test_back_to_back;
      test_wrap;
      test_random_ready;
      test_mid_reset;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
